hw_to_sw_tx: RTL and testbench

- Hardware-to-software byte transmitter. It is the return path beside the existing software-to-hardware PIO channel (to_hw_data / to_hw_sig).
- Game logic (collision, score, level-end events) pushes bytes into a small FIFO.
- The block presents each byte to the Nios II on a PIO pair (to_sw_data / to_sw_sig) using a 4-phase handshake, acknowledged through a dedicated 2-bit PIO (sw_ack).
- Everything runs on the 50 MHz system clock, the same domain as the Nios II PIOs.

---
 rtl/hw_to_sw_tx.sv | 135 +++++++++++++
 tb/tb_hw_to_sw_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hw_to_sw_tx.sv
// rtl/hw_to_sw_tx.sv - event byte FIFO presented to software over a 4-phase PIO handshake
module hw_to_sw_tx #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic                   clk50,
  input  logic                   reset_n,
  input  logic                   ev_valid,
  input  logic [7:0]             ev_data,
  output logic                   ev_ready,
  input  logic [1:0]             sw_ack,
  output logic [1:0]             to_sw_sig,
  output logic [7:0]             to_sw_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            loss_q, loss_d;
  logic            full, push, pop, overflow, tmo_drop;

  assign full     = (count_q == FULL_CNT);
  // A full FIFO rejects the push even if a pop frees a slot this same cycle.
  assign push     = ev_valid && !full;
  assign overflow = ev_valid && full;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    pop      = 1'b0;
    tmo_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          data_d  = mem_q[rd_ptr_q];
          tmo_d   = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (sw_ack == 2'b01) begin
          pop     = 1'b1;
          state_d = RELEASE;
        end else if (TIMEOUT != 0 && tmo_q == TO_LAST) begin
          pop      = 1'b1;
          tmo_drop = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RELEASE: begin
        // Reserved code 10 behaves like a release.
        if (sw_ack[0] == 1'b0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    loss_d = loss_q;
    if (overflow || tmo_drop) begin
      loss_d = 1'b1;
    end else if (sw_ack == 2'b11) begin
      loss_d = 1'b0;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      loss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      loss_q  <= loss_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ev_data;
    end
  end

  assign ev_ready   = !full;
  assign to_sw_sig  = {loss_q, (state_q == PRESENT)};
  assign to_sw_data = data_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hw_to_sw_tx.sv
// tb/tb_hw_to_sw_tx.sv - directed self-checking bench for hw_to_sw_tx
module tb_hw_to_sw_tx;

  logic       clk50 = 1'b0;
  logic       reset_n;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_ready;
  logic [1:0] sw_ack;
  logic [1:0] to_sw_sig;
  logic [7:0] to_sw_data;
  logic [3:0] fifo_count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  hw_to_sw_tx #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_ready   (ev_ready),
    .sw_ack     (sw_ack),
    .to_sw_sig  (to_sw_sig),
    .to_sw_data (to_sw_data),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (to_sw_sig[0] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 32'(to_sw_sig[0]), 1);
  endtask

  initial begin
    int present_cycles;
    reset_n  = 1'b0;
    ev_valid = 1'b0;
    ev_data  = 8'h00;
    sw_ack   = 2'b00;
    tick();
    tick();
    check("rst_sig",   32'(to_sw_sig),  0);
    check("rst_data",  32'(to_sw_data), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy",  32'(busy),       0);
    check("rst_ready", 32'(ev_ready),   1);
    reset_n = 1'b1;
    tick();

    // Single byte
    ev_valid = 1'b1;
    ev_data  = 8'h5A;
    tick();
    ev_valid = 1'b0;
    check("single_count_n1", 32'(fifo_count), 1);
    check("single_sig_n1",   32'(to_sw_sig),  0);
    tick();
    check("single_sig_n2",  32'(to_sw_sig),  1);
    check("single_data_n2", 32'(to_sw_data), 8'h5A);
    sw_ack = 2'b01;
    tick();
    check("single_sig_ack",   32'(to_sw_sig),  0);
    check("single_count_ack", 32'(fifo_count), 0);
    check("single_busy_rel",  32'(busy),       1);
    sw_ack = 2'b00;
    tick();
    check("single_busy_idle", 32'(busy), 0);
    check("single_data_hold", 32'(to_sw_data), 8'h5A);

    // Fill and overflow
    for (int i = 1; i <= 9; i++) begin
      ev_valid = 1'b1;
      ev_data  = 8'(i);
      tick();
      if (i == 8) begin
        check("fill_ready8", 32'(ev_ready),   0);
        check("fill_count8", 32'(fifo_count), 8);
        check("fill_loss8",  32'(to_sw_sig[1]), 0);
      end
    end
    ev_valid = 1'b0;
    check("ovf_count", 32'(fifo_count), 8);
    check("ovf_sig",   32'(to_sw_sig),  3);

    // Clear racing an overflow push: set wins
    sw_ack   = 2'b11;
    ev_valid = 1'b1;
    ev_data  = 8'h0A;
    tick();
    ev_valid = 1'b0;
    check("clr_race_loss",  32'(to_sw_sig[1]), 1);
    check("clr_race_count", 32'(fifo_count),   8);
    tick();
    sw_ack = 2'b00;
    check("clr_loss",  32'(to_sw_sig[1]), 0);
    check("clr_count", 32'(fifo_count),   8);
    check("clr_valid", 32'(to_sw_sig[0]), 1);

    // Drain in order; read pointer wraps
    for (int i = 1; i <= 8; i++) begin
      wait_valid("drain_valid");
      check("drain_data", 32'(to_sw_data), i);
      sw_ack = 2'b01;
      tick();
      check("drain_sig", 32'(to_sw_sig[0]), 0);
      check("drain_count", 32'(fifo_count), 8 - i);
      sw_ack = 2'b00;
      tick();
    end
    tick();
    check("drain_busy", 32'(busy), 0);
    check("drain_sig_end", 32'(to_sw_sig), 0);

    // Timeout
    ev_valid = 1'b1;
    ev_data  = 8'hAA;
    tick();
    ev_data  = 8'hBB;
    tick();
    ev_valid = 1'b0;
    check("tmo_first_valid", 32'(to_sw_sig), 1);
    check("tmo_first_data",  32'(to_sw_data), 8'hAA);
    check("tmo_first_count", 32'(fifo_count), 2);
    present_cycles = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (to_sw_sig[0] == 1'b1) present_cycles++;
    end
    check("tmo_present_cycles", present_cycles, 16);
    tick();
    check("tmo_sig",   32'(to_sw_sig),  2);
    check("tmo_busy",  32'(busy),       0);
    check("tmo_count", 32'(fifo_count), 1);
    tick();
    check("tmo_next_sig",  32'(to_sw_sig),  3);
    check("tmo_next_data", 32'(to_sw_data), 8'hBB);

    // Code 11 in PRESENT clears the flag but is not an ack
    sw_ack = 2'b11;
    tick();
    check("clr11_sig",   32'(to_sw_sig),  1);
    check("clr11_count", 32'(fifo_count), 1);

    // Push during handshake
    sw_ack = 2'b01;
    tick();
    check("hs_rel_sig", 32'(to_sw_sig), 0);
    ev_valid = 1'b1;
    ev_data  = 8'h33;
    tick();
    ev_valid = 1'b0;
    check("hs_count", 32'(fifo_count), 1);
    check("hs_data_hold", 32'(to_sw_data), 8'hBB);
    tick();
    check("hs_still_rel", 32'(busy), 1);
    check("hs_data_hold2", 32'(to_sw_data), 8'hBB);
    sw_ack = 2'b00;
    tick();
    check("hs_idle_sig",  32'(to_sw_sig),  0);
    check("hs_idle_data", 32'(to_sw_data), 8'hBB);
    tick();
    check("hs_new_sig",  32'(to_sw_sig),  1);
    check("hs_new_data", 32'(to_sw_data), 8'h33);

    // Reset mid-PRESENT
    ev_valid = 1'b1;
    ev_data  = 8'h44;
    tick();
    ev_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_sig",   32'(to_sw_sig),  0);
    check("arst_data",  32'(to_sw_data), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_busy",  32'(busy),       0);
    check("arst_ready", 32'(ev_ready),   1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_sig",   32'(to_sw_sig),  0);
    check("post_rst_count", 32'(fifo_count), 0);
    check("post_rst_busy",  32'(busy),       0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
